decode_hazard_ctrl: RTL

- Decode-stage issue controller that sits directly upstream of the register scoreboard.
- Each cycle it compares the decode instruction's source registers against the scoreboard's per-register invalid counters. It then decides to issue, stall, or bubble the instruction.
- It drives the scoreboard's update controls: regwrite_cur and flush_decode.
- It tracks memory-wait and branch-flush events with a small FSM and a stall watchdog.

---
 rtl/core_pkg.sv | 15 +
 rtl/decode_hazard_ctrl_stall_watchdog.sv | 40 ++++
 rtl/decode_hazard_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared decode/scoreboard definitions: register file geometry and the
// hazard controller's stall-cause encoding.
package core_pkg;

  localparam int NREG  = 8;
  localparam int ADR_W = 3;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HAZARD  = 2'd1,
    MEMWAIT = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/decode_hazard_ctrl_stall_watchdog.sv
// Saturating consecutive-stall counter with a sticky timeout flag that
// trips once the count reaches MAX_STALL while the controller sits in HAZARD.
module stall_watchdog #(
  parameter int MAX_STALL = 15,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic             hold,
  input  logic             in_hazard,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             hazard_timeout
);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL);

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt      <= '0;
      hazard_timeout <= 1'b0;
    end else begin
      // A frozen pipeline neither counts nor clears the stall run.
      if (!hold) begin
        if (clr) begin
          stall_cnt <= '0;
        end else if (inc && stall_cnt != CNT_SAT) begin
          stall_cnt <= stall_cnt + 1'b1;
        end
      end
      if (in_hazard && stall_cnt >= CNT_MAX) begin
        hazard_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage issue controller: issues, stalls or bubbles the decode
// instruction against the scoreboard counters. Define DECODE_HAZARD_FWD_EN
// to treat a counter of 1 as valid (execute-stage forwarding).
module decode_hazard_ctrl
  import core_pkg::*;
#(
  parameter int MAX_STALL   = 15,
  parameter int STALL_CNT_W = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             valid_id,
  input  logic [ADR_W-1:0]                 rs_adr_id,
  input  logic                             rs_used_id,
  input  logic [ADR_W-1:0]                 rt_adr_id,
  input  logic                             rt_used_id,
  input  logic                             regwrite_id,
  input  logic                             branch_taken_ex,
  input  logic                             memory_waiting,
  input  logic [NREG-1:0][CNT_W-1:0]       register_invalid,
  output logic                             stall_decode,
  output logic                             flush_decode,
  output logic                             regwrite_cur,
  output logic [STALL_CNT_W-1:0]           stall_cnt,
  output logic                             hazard_timeout
);

  hazard_state_t state_q, state_d;
  logic rs_pending, rt_pending, hz;
  logic wd_inc, wd_clr, wd_hold;

`ifdef DECODE_HAZARD_FWD_EN
  assign rs_pending = register_invalid[rs_adr_id] > CNT_W'(1);
  assign rt_pending = register_invalid[rt_adr_id] > CNT_W'(1);
`else
  assign rs_pending = register_invalid[rs_adr_id] != '0;
  assign rt_pending = register_invalid[rt_adr_id] != '0;
`endif

  // Only the scoreboard is consulted, so a source matching the instruction's
  // own destination never self-hazards.
  assign hz = valid_id & ((rs_used_id & rs_pending) | (rt_used_id & rt_pending));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = RUN;
    if (memory_waiting)       state_d = MEMWAIT;
    else if (branch_taken_ex) state_d = RUN;
    else if (hz)              state_d = HAZARD;
  end

  always_comb begin
    stall_decode = 1'b0;
    flush_decode = 1'b0;
    regwrite_cur = 1'b0;
    wd_inc       = 1'b0;
    wd_clr       = 1'b0;
    wd_hold      = 1'b0;
    if (!reset) begin
      wd_clr = 1'b1;
    end else if (memory_waiting) begin
      stall_decode = 1'b1;
      wd_hold      = 1'b1;
    end else if (branch_taken_ex) begin
      flush_decode = 1'b1;
      wd_clr       = 1'b1;
    end else if (hz) begin
      stall_decode = 1'b1;
      flush_decode = 1'b1;
      wd_inc       = 1'b1;
    end else begin
      regwrite_cur = valid_id & regwrite_id;
      wd_clr       = 1'b1;
    end
  end

  stall_watchdog #(
    .MAX_STALL (MAX_STALL),
    .CNT_W     (STALL_CNT_W)
  ) u_watchdog (
    .clk            (clk),
    .reset          (reset),
    .inc            (wd_inc),
    .clr            (wd_clr),
    .hold           (wd_hold),
    .in_hazard      (state_q == HAZARD),
    .stall_cnt      (stall_cnt),
    .hazard_timeout (hazard_timeout)
  );

endmodule
